// File: rtl/sweep_scheduler.sv
// Generation sequencer that hands grid columns to a shared pool of diffusion solvers.
// The block runs an init pass after restart, then one update pass per generation, with run/step/halt control.
module sweep_scheduler #(
  parameter int NUM_COLS    = 8,
  parameter int NUM_SOLVERS = 2,
  parameter int COL_W       = 3,
  parameter int GEN_W       = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         run,
  input  logic                         step,
  input  logic                         restart,
  input  logic [GEN_W-1:0]             max_gen,
  input  logic [NUM_SOLVERS-1:0]       solver_done,
  input  logic [NUM_SOLVERS-1:0]       solver_edge_frozen,
  output logic [NUM_SOLVERS-1:0]       solver_start,
  output logic [NUM_SOLVERS*COL_W-1:0] solver_col,
  output logic                         solver_init,
  output logic [GEN_W-1:0]             gen_count,
  output logic                         gen_done,
  output logic                         busy,
  output logic                         halted,
  output logic                         protocol_err
);

  // One extra pointer bit so the pointer can hold NUM_COLS itself (the "all dispatched" value).
  localparam int PTR_W = COL_W + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_COLS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_DISPATCH,
    S_DRAIN,
    S_GEN_END,
    S_HALT
  } state_t;

  state_t                   state_reg, state_next;
  logic [PTR_W-1:0]         ptr_reg, ptr_next, ptr_dispatched;
  logic [NUM_SOLVERS-1:0]   busy_reg, busy_next;
  logic [NUM_SOLVERS-1:0]   start_reg, start_next;
  logic [COL_W-1:0]         col_reg  [NUM_SOLVERS];
  logic [COL_W-1:0]         col_next [NUM_SOLVERS];
  logic                     step_latch_reg, step_latch_next;
  logic                     edge_latch_reg, edge_latch_next;
  logic                     err_reg, err_next;
  logic [GEN_W-1:0]         gen_reg, gen_next, gen_inc;
  logic [NUM_SOLVERS-1:0]   valid_done;
  logic                     spurious_done;
  logic                     dispatch_en;

  assign valid_done    = solver_done & busy_reg;
  assign spurious_done = |(solver_done & ~busy_reg);
  assign dispatch_en   = (state_reg == S_INIT) || (state_reg == S_DISPATCH);
  assign gen_inc       = gen_reg + GEN_W'(1);

  // Free solvers claim consecutive columns in ascending solver order within one cycle.
  always_comb begin
    logic [PTR_W-1:0] scan;
    scan       = ptr_reg;
    start_next = '0;
    for (int k = 0; k < NUM_SOLVERS; k++) begin
      col_next[k] = col_reg[k];
      if (dispatch_en && !busy_reg[k] && (scan < LAST_PTR)) begin
        start_next[k] = 1'b1;
        col_next[k]   = scan[COL_W-1:0];
        scan          = scan + PTR_W'(1);
      end
    end
    ptr_dispatched = scan;
  end

  assign busy_next = (busy_reg & ~valid_done) | start_next;

  always_comb begin
    state_next      = state_reg;
    ptr_next        = dispatch_en ? ptr_dispatched : ptr_reg;
    step_latch_next = step_latch_reg;
    edge_latch_next = edge_latch_reg | |(valid_done & solver_edge_frozen);
    err_next        = err_reg | spurious_done;
    gen_next        = gen_reg;
    case (state_reg)
      S_IDLE: begin
        if (restart) begin
          state_next      = S_INIT;
          ptr_next        = '0;
          gen_next        = '0;
          step_latch_next = 1'b0;
          edge_latch_next = 1'b0;
          err_next        = spurious_done | step;
        end else if (run || step_latch_reg) begin
          state_next      = S_DISPATCH;
          ptr_next        = '0;
          edge_latch_next = 1'b0;
        end else if (step) begin
          step_latch_next = 1'b1;
        end
      end
      S_INIT: begin
        if ((ptr_reg == LAST_PTR) && (busy_reg == '0)) state_next = S_IDLE;
      end
      S_DISPATCH: begin
        if (ptr_dispatched == LAST_PTR) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (busy_reg == '0) state_next = S_GEN_END;
      end
      S_GEN_END: begin
        gen_next = gen_inc;
        if (edge_latch_reg) begin
          state_next = S_HALT;
        end else if ((max_gen != '0) && (gen_inc == max_gen)) begin
          state_next = S_HALT;
        end else if (run) begin
          state_next      = S_DISPATCH;
          ptr_next        = '0;
          edge_latch_next = 1'b0;
        end else begin
          state_next      = S_IDLE;
          step_latch_next = 1'b0;
        end
      end
      S_HALT: begin
        if (restart) begin
          state_next      = S_INIT;
          ptr_next        = '0;
          gen_next        = '0;
          step_latch_next = 1'b0;
          edge_latch_next = 1'b0;
          err_next        = spurious_done;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= S_IDLE;
      ptr_reg        <= '0;
      busy_reg       <= '0;
      start_reg      <= '0;
      step_latch_reg <= 1'b0;
      edge_latch_reg <= 1'b0;
      err_reg        <= 1'b0;
      gen_reg        <= '0;
      for (int k = 0; k < NUM_SOLVERS; k++) col_reg[k] <= '0;
    end else begin
      state_reg      <= state_next;
      ptr_reg        <= ptr_next;
      busy_reg       <= busy_next;
      start_reg      <= start_next;
      step_latch_reg <= step_latch_next;
      edge_latch_reg <= edge_latch_next;
      err_reg        <= err_next;
      gen_reg        <= gen_next;
      for (int k = 0; k < NUM_SOLVERS; k++) col_reg[k] <= col_next[k];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SOLVERS; gi++) begin : g_col_out
      assign solver_col[gi*COL_W +: COL_W] = col_reg[gi];
    end
  endgenerate

  assign solver_start = start_reg;
  assign solver_init  = (state_reg == S_INIT);
  assign gen_count    = gen_reg;
  assign gen_done     = (state_reg == S_GEN_END);
  assign busy         = (state_reg == S_INIT) || (state_reg == S_DISPATCH) || (state_reg == S_DRAIN);
  assign halted       = (state_reg == S_HALT);
  assign protocol_err = err_reg;

endmodule
